// File: rtl/raster_cmd_dispatcher_pkg.sv
// Shared types and framebuffer limits for the rasterizer command dispatcher.
package raster_cmd_dispatcher_pkg;

    localparam int RASTER_X_W = 8;
    localparam int RASTER_Y_W = 8;

    localparam logic [RASTER_X_W-1:0] FB_WIDTH  = RASTER_X_W'(214);
    localparam logic [RASTER_Y_W-1:0] FB_HEIGHT = RASTER_Y_W'(160);
    localparam logic [RASTER_X_W-1:0] FB_X_MAX  = RASTER_X_W'(213);
    localparam logic [RASTER_Y_W-1:0] FB_Y_MAX  = RASTER_Y_W'(159);

    typedef enum logic [1:0] {
        RASTER_CMD_FILL  = 2'd0,
        RASTER_CMD_LINE  = 2'd1,
        RASTER_CMD_RECT  = 2'd2,
        RASTER_CMD_POINT = 2'd3
    } raster_command_t;

    typedef struct packed {
        raster_command_t         command;
        logic [2:0]              colour;
        logic [RASTER_X_W-1:0]   x0;
        logic [RASTER_Y_W-1:0]   y0;
        logic [RASTER_X_W-1:0]   x1;
        logic [RASTER_Y_W-1:0]   y1;
    } raster_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } disp_state_t;

endpackage

// File: rtl/raster_cmd_dispatcher_if.sv
// CPU push/fence port and rasterizer command port of the dispatcher.
// master = dispatcher view; slave = CPU plus rasterizer view.
interface raster_cmd_dispatcher_if
    import raster_cmd_dispatcher_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int X_WIDTH = RASTER_X_W,
    parameter int Y_WIDTH = RASTER_Y_W
) ();

    logic                       push_valid;
    logic                       push_ready;
    raster_op_t                 push_op;
    logic                       fence_req;
    logic                       fence_ack;
    logic [$clog2(DEPTH+1)-1:0] level;
    raster_command_t            command;
    logic [2:0]                 colour;
    logic [X_WIDTH-1:0]         x0;
    logic [X_WIDTH-1:0]         x1;
    logic [Y_WIDTH-1:0]         y0;
    logic [Y_WIDTH-1:0]         y1;
    logic                       execute_request;
    logic                       raster_ready;
    logic                       raster_busy;

    modport master (
        input  push_valid, push_op, fence_req, raster_ready, raster_busy,
        output push_ready, fence_ack, level, command, colour, x0, x1, y0, y1,
               execute_request
    );

    modport slave (
        output push_valid, push_op, fence_req, raster_ready, raster_busy,
        input  push_ready, fence_ack, level, command, colour, x0, x1, y0, y1,
               execute_request
    );

endinterface

// File: rtl/raster_cmd_dispatcher_sync_fifo.sv
// Single-clock FIFO with show-ahead head and registered occupancy count.
module raster_cmd_dispatcher_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst_async,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !rd_en) begin
                count <= count + CNT_W'(1);
            end else if (!wr_en && rd_en) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/raster_cmd_dispatcher.sv
// Buffers CPU draw ops and issues them one at a time to the rasterizer; provides a fence.
module raster_cmd_dispatcher
    import raster_cmd_dispatcher_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int X_WIDTH = RASTER_X_W,
    parameter int Y_WIDTH = RASTER_Y_W
) (
    input logic                     clk,
    input logic                     n_rst_async,
    raster_cmd_dispatcher_if.master bus
);

    localparam int LEVEL_W = $clog2(DEPTH + 1);

    function automatic logic [RASTER_X_W-1:0] sat_x(input logic [RASTER_X_W-1:0] x);
        return (x >= FB_WIDTH) ? FB_X_MAX : x;
    endfunction

    function automatic logic [RASTER_Y_W-1:0] sat_y(input logic [RASTER_Y_W-1:0] y);
        return (y >= FB_HEIGHT) ? FB_Y_MAX : y;
    endfunction

    function automatic raster_op_t clamp_op(input raster_op_t op);
        raster_op_t r;
        r    = op;
        r.x0 = sat_x(op.x0);
        r.x1 = sat_x(op.x1);
        r.y0 = sat_y(op.y0);
        r.y1 = sat_y(op.y1);
        return r;
    endfunction

    disp_state_t        state;
    disp_state_t        state_nxt;
    logic [LEVEL_W-1:0] level;
    raster_op_t         head;
    raster_op_t         out_q;
    logic               rst_done_q;
    logic               push_ready;
    logic               push_fire;
    logic               queue_nonempty;
    logic               pop;
    logic               exec_nxt;
    logic               exec_q;
    logic               fence_hit;
    logic               fence_ack_q;

    // Ready comes from the registered level, so a same-cycle pop never frees a slot.
    assign push_ready     = rst_done_q && (level != LEVEL_W'(DEPTH));
    assign push_fire      = bus.push_valid && push_ready;
    assign queue_nonempty = (level != '0);

    raster_cmd_dispatcher_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(raster_op_t))
    ) u_fifo (
        .clk         (clk),
        .n_rst_async (n_rst_async),
        .wr_en       (push_fire),
        .wr_data     (clamp_op(bus.push_op)),
        .rd_en       (pop),
        .rd_data     (head),
        .count       (level)
    );

    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (queue_nonempty) state_nxt = ST_ISSUE;
            ST_ISSUE: if (bus.raster_ready) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!bus.raster_busy) state_nxt = queue_nonempty ? ST_ISSUE : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        pop       = 1'b0;
        fence_hit = 1'b0;
        exec_nxt  = exec_q;
        unique case (state)
            ST_IDLE: begin
                pop       = queue_nonempty;
                fence_hit = bus.fence_req && !queue_nonempty && !bus.raster_busy && !push_fire;
            end
            ST_ISSUE: if (bus.raster_ready) exec_nxt = 1'b0;
            ST_DRAIN: pop = !bus.raster_busy && queue_nonempty;
            default: ;
        endcase
        if (pop) begin
            exec_nxt = 1'b1;
        end
    end

    // Output registers only change when a new op is taken from the queue.
    always_ff @(posedge clk or negedge n_rst_async) begin
        if (!n_rst_async) begin
            rst_done_q    <= 1'b0;
            exec_q        <= 1'b0;
            fence_ack_q   <= 1'b0;
            out_q.command <= RASTER_CMD_FILL;
            out_q.colour  <= '0;
            out_q.x0      <= '0;
            out_q.y0      <= '0;
            out_q.x1      <= '0;
            out_q.y1      <= '0;
        end else begin
            rst_done_q  <= 1'b1;
            exec_q      <= exec_nxt;
            fence_ack_q <= fence_hit;
            if (pop) begin
                out_q <= head;
            end
        end
    end

    assign bus.push_ready      = push_ready;
    assign bus.level           = level;
    assign bus.fence_ack       = fence_ack_q;
    assign bus.execute_request = exec_q;
    assign bus.command         = out_q.command;
    assign bus.colour          = out_q.colour;
    assign bus.x0              = out_q.x0;
    assign bus.y0              = out_q.y0;
    assign bus.x1              = out_q.x1;
    assign bus.y1              = out_q.y1;

endmodule

// File: tb/tb_raster_cmd_dispatcher.sv
// Randomized scoreboard bench for raster_cmd_dispatcher with a small rasterizer model.
module tb_raster_cmd_dispatcher;
    import raster_cmd_dispatcher_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic n_rst_async;
    always #10 clk = ~clk;

    raster_cmd_dispatcher_if #(.DEPTH(DEPTH)) bus ();

    raster_cmd_dispatcher #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .n_rst_async (n_rst_async),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    raster_op_t exp_q[$];
    raster_op_t cur_op;
    int ready_pct = 0;
    int busy_len  = 0;
    int cyc = 0;
    int n_issued = 0;
    int n_ack = 0;
    int last_acc_cyc = 0;
    int last_gap = 0;
    int busy_fall_cyc = 0;
    int ack_rise_cyc = -1;
    int busy_cnt = 0;
    bit prev_exec = 0, prev_ready = 0, prev_ack = 0, prev_busy = 0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    endfunction

    // Reference: coordinates outside the 214x160 framebuffer clamp to the last pixel.
    function automatic raster_op_t model_op(input raster_op_t op);
        raster_op_t r = op;
        if (int'(op.x0) >= 214) r.x0 = 8'd213;
        if (int'(op.x1) >= 214) r.x1 = 8'd213;
        if (int'(op.y0) >= 160) r.y0 = 8'd159;
        if (int'(op.y1) >= 160) r.y1 = 8'd159;
        return r;
    endfunction

    function automatic raster_op_t get_out();
        raster_op_t r;
        r.command = bus.command;
        r.colour  = bus.colour;
        r.x0 = bus.x0;
        r.y0 = bus.y0;
        r.x1 = bus.x1;
        r.y1 = bus.y1;
        return r;
    endfunction

    function automatic raster_op_t rand_op();
        raster_op_t r;
        r.command = raster_command_t'(2'($urandom_range(0, 3)));
        r.colour  = 3'($urandom);
        r.x0 = 8'($urandom);
        r.y0 = 8'($urandom);
        r.x1 = 8'($urandom);
        r.y1 = 8'($urandom);
        return r;
    endfunction

    // Monitor and rasterizer model share one process so their bookkeeping never races.
    initial begin : rast_mon
        raster_op_t e;
        bus.raster_ready = 1'b0;
        bus.raster_busy  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (prev_exec && prev_ready) begin
                last_acc_cyc = cyc;
                busy_cnt = (busy_len < 0) ? int'($urandom_range(0, 3)) : busy_len;
            end
            if (bus.execute_request && !prev_exec) begin
                n_issued++;
                last_gap = cyc - last_acc_cyc;
                cur_op = get_out();
                if (exp_q.size() == 0) begin
                    check("issue_unexpected", 64'(n_issued), 64'(n_issued - 1));
                end else begin
                    e = exp_q.pop_front();
                    check("issue_op", 64'(cur_op), 64'(e));
                end
            end else if (bus.execute_request && prev_exec) begin
                check("issue_stable", 64'(get_out()), 64'(cur_op));
            end
            if (bus.fence_ack) n_ack++;
            if (bus.fence_ack && !prev_ack && ack_rise_cyc < 0) ack_rise_cyc = cyc;
            prev_exec = bus.execute_request;
            prev_ack  = bus.fence_ack;
            prev_busy = bus.raster_busy;
            bus.raster_busy = (busy_cnt > 0);
            if (busy_cnt > 0) busy_cnt--;
            if (prev_busy && !bus.raster_busy) busy_fall_cyc = cyc;
            bus.raster_ready = (ready_pct >= 100) ? 1'b1 :
                               (ready_pct <= 0)   ? 1'b0 :
                               (int'($urandom_range(0, 99)) < ready_pct);
            prev_ready = bus.raster_ready;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_push(input raster_op_t op);
        int t = 0;
        tick();
        while (!bus.push_ready && t < 200) begin
            tick();
            t++;
        end
        if (!bus.push_ready) begin
            check("push_timeout", 64'(bus.push_ready), 64'(1));
        end else begin
            bus.push_valid = 1'b1;
            bus.push_op    = op;
            exp_q.push_back(model_op(op));
            tick();
            bus.push_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || bus.execute_request || bus.raster_busy || bus.level != 0) && t < 2000) begin
            tick();
            t++;
        end
        tick(2);
        check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        raster_op_t op;
        int base;
        int t;
        n_rst_async    = 1'b0;
        bus.push_valid = 1'b0;
        bus.push_op    = '0;
        bus.fence_req  = 1'b0;
        tick(3);
        check("rst_push_ready", 64'(bus.push_ready), 64'(0));
        check("rst_exec", 64'(bus.execute_request), 64'(0));
        check("rst_level", 64'(bus.level), 64'(0));
        n_rst_async = 1'b1;
        tick();
        check("post_rst_push_ready", 64'(bus.push_ready), 64'(1));
        check("post_rst_fence_ack", 64'(bus.fence_ack), 64'(0));
        check("post_rst_outputs", 64'(get_out()), 64'(0));

        // Single FILL op with an always-ready rasterizer.
        ready_pct = 100;
        busy_len  = 0;
        op = '0;
        op.command = RASTER_CMD_FILL;
        op.colour  = 3'b101;
        op.x0 = 8'd10; op.y0 = 8'd20; op.x1 = 8'd30; op.y1 = 8'd40;
        do_push(op);
        check("t1_level_after_push", 64'(bus.level), 64'(1));
        check("t1_exec_not_yet", 64'(bus.execute_request), 64'(0));
        tick();
        check("t1_exec_high", 64'(bus.execute_request), 64'(1));
        check("t1_level_after_pop", 64'(bus.level), 64'(0));
        check("t1_command", 64'(bus.command), 64'(RASTER_CMD_FILL));
        check("t1_colour", 64'(bus.colour), 64'(5));
        tick();
        check("t1_exec_dropped", 64'(bus.execute_request), 64'(0));
        wait_drain("t1");

        // Fill the queue with the rasterizer stalled.
        ready_pct = 0;
        base = n_issued;
        for (int i = 0; i < DEPTH + 1; i++) do_push(rand_op());
        check("t2_level_full", 64'(bus.level), 64'(DEPTH));
        check("t2_push_ready_full", 64'(bus.push_ready), 64'(0));
        bus.push_valid = 1'b1;
        bus.push_op    = rand_op();
        tick();
        bus.push_valid = 1'b0;
        check("t2_level_after_ignored", 64'(bus.level), 64'(DEPTH));
        ready_pct = 100;
        wait_drain("t2");
        check("t2_issue_count", 64'(n_issued - base), 64'(DEPTH + 1));

        // Coordinate saturation.
        base = n_issued;
        op = '0;
        op.command = RASTER_CMD_LINE;
        op.colour  = 3'd2;
        op.x0 = 8'd250; op.y0 = 8'd159; op.x1 = 8'd213; op.y1 = 8'd200;
        do_push(op);
        t = 0;
        while (n_issued == base && t < 50) begin tick(); t++; end
        check("t3_x0_sat", 64'(bus.x0), 64'(213));
        check("t3_y1_sat", 64'(bus.y1), 64'(159));
        check("t3_y0_pass", 64'(bus.y0), 64'(159));
        check("t3_x1_pass", 64'(bus.x1), 64'(213));
        op.x0 = 8'd214; op.y0 = 8'd160; op.x1 = 8'd0; op.y1 = 8'd7;
        do_push(op);
        wait_drain("t3");

        // Long busy after accept holds off the next issue.
        busy_len = 20;
        base = n_issued;
        do_push(rand_op());
        do_push(rand_op());
        t = 0;
        while (n_issued < base + 2 && t < 100) begin tick(); t++; end
        check("t4_issue_gap", 64'(last_gap), 64'(21));
        wait_drain("t4");

        // Fence waits for queued work and rasterizer idle.
        ready_pct = 0;
        busy_len  = 3;
        base = n_issued;
        for (int i = 0; i < 4; i++) do_push(rand_op());
        check("t5_level", 64'(bus.level), 64'(3));
        bus.fence_req = 1'b1;
        n_ack = 0;
        ack_rise_cyc = -1;
        tick(10);
        check("t5_no_early_ack", 64'(n_ack), 64'(0));
        ready_pct = 100;
        t = 0;
        while (ack_rise_cyc < 0 && t < 300) begin tick(); t++; end
        check("t5_all_issued", 64'(n_issued - base), 64'(4));
        check("t5_ack_delay", 64'(ack_rise_cyc - busy_fall_cyc), 64'(2));
        tick();
        check("t5_ack_repulse", 64'(bus.fence_ack), 64'(1));
        bus.fence_req = 1'b0;
        tick();
        check("t5_ack_release", 64'(bus.fence_ack), 64'(0));

        // Reset while an op is being issued.
        ready_pct = 0;
        busy_len  = 0;
        for (int i = 0; i < 3; i++) do_push(rand_op());
        check("t6_exec_before", 64'(bus.execute_request), 64'(1));
        n_rst_async = 1'b0;
        #1;
        check("t6_exec_async", 64'(bus.execute_request), 64'(0));
        check("t6_level_async", 64'(bus.level), 64'(0));
        exp_q.delete();
        base = n_issued;
        tick(2);
        n_rst_async = 1'b1;
        ready_pct = 100;
        tick(20);
        check("t6_no_stale", 64'(n_issued - base), 64'(0));
        check("t6_level_after", 64'(bus.level), 64'(0));

        // Random traffic with a jittery rasterizer.
        ready_pct = 60;
        busy_len  = -1;
        for (int i = 0; i < 40; i++) begin
            do_push(rand_op());
            tick(int'($urandom_range(0, 2)));
        end
        wait_drain("t7");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
